shared_timer_arb: RTL and testbench

SHARED_TIMER_ARB -- requirements
Module: shared_timer_arb

---
 rtl/shared_timer_arb.sv | 163 ++++++++++++++++
 tb/tb_shared_timer_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_timer_arb.sv
// shared_timer_arb: round-robin arbiter that lends one shared up-counter to
// NREQ requesters. The winner's terminal count is latched at grant; the
// grant is held for target+1 cycles (count 0..target), then a one-cycle done
// pulse is issued and the winner drops to lowest priority.
//
// Parameters : NREQ (2..8) requesters, W counter/length width.
// Ports      : clk           rising-edge clock
//              rst           synchronous active-low reset
//              req[NREQ]     level requests
//              len[NREQ*W]   per-requester terminal count, len[i*W +: W]
//              gnt[NREQ]     one-hot grant (registered)
//              done[NREQ]    one-cycle completion pulse (registered)
//              busy          high whenever the FSM is not in IDLE (registered)
//              count[W]      shared counter value (registered)
// Option     : `define SHARED_TIMER_ABORT_EN lets the granted requester end its
//              run early by dropping req; the run is abandoned without a done.
module shared_timer_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      count
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_count, w_count_nxt;
  logic [W-1:0]    r_target, w_target_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [PW-1:0]   r_sel, w_sel_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic            r_busy, w_busy_nxt;

  logic            w_found;
  logic [PW-1:0]   w_sel;
  logic [PW-1:0]   w_cand;
  logic [PW-1:0]   w_ptr_inc;
  logic [W-1:0]    w_len_arr [NREQ];

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Unpack the flat length bus into one entry per requester.
  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign w_len_arr[g] = len[g*W +: W];
  end

  // Round-robin pick: first set req bit scanning upward from r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = PW'((32'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  // The pointer moves past the finishing requester so it loses the next tie.
  assign w_ptr_inc = (r_sel == PW'(NREQ - 1)) ? '0 : r_sel + PW'(1);

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_target_nxt = r_target;
    w_ptr_nxt    = r_ptr;
    w_sel_nxt    = r_sel;
    w_gnt_nxt    = r_gnt;
    w_done_nxt   = '0;
    w_busy_nxt   = r_busy;
    case (r_state)
      IDLE: begin
        w_count_nxt = '0;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        if (w_found) begin
          w_state_nxt  = RUN;
          w_sel_nxt    = w_sel;
          w_target_nxt = w_len_arr[w_sel];
          w_gnt_nxt    = onehot(w_sel);
          w_busy_nxt   = 1'b1;
        end
      end
      RUN: begin
`ifdef SHARED_TIMER_ABORT_EN
        if (!req[r_sel]) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_count_nxt = '0;
          w_ptr_nxt   = w_ptr_inc;
          w_busy_nxt  = 1'b0;
        end else
`endif
        if (r_count == r_target) begin
          w_state_nxt = DONE;
          w_gnt_nxt   = '0;
          w_done_nxt  = onehot(r_sel);
          w_count_nxt = '0;
          w_ptr_nxt   = w_ptr_inc;
        end else begin
          w_count_nxt = r_count + W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_count_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_target <= '0;
      r_ptr    <= '0;
      r_sel    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_target <= w_target_nxt;
      r_ptr    <= w_ptr_nxt;
      r_sel    <= w_sel_nxt;
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign busy  = r_busy;
  assign count = r_count;

endmodule

// File: tb/tb_shared_timer_arb.sv
// Directed bench for shared_timer_arb (NREQ=4, W=8). Stimulus pushes the
// expected grant record (who, how many cycles, aborted or not) into a queue;
// the monitor reconstructs each grant from gnt/count and checks it against
// the queue head when the grant ends.
module tb_shared_timer_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] len;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  count;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [31:0] cycles;
    logic        aborted;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  shared_timer_arb #(.NREQ(4), .W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input int unsigned cyc, input bit ab);
    exp_t e;
    e.gnt     = g;
    e.cycles  = cyc;
    e.aborted = ab;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done != 4'b0) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_count(input logic [3:0] g, input logic [7:0] c, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (gnt == g && count == c) seen = 1'b1;
    end
    chk("count_reached", 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: rebuilds each grant and scores it against the queue at its end.
  logic [3:0]  prev_gnt = 4'b0;
  logic [3:0]  run_gnt  = 4'b0;
  int unsigned run_len  = 0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (gnt != 4'b0) begin
        chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
        chk("busy_in_run", 32'(busy), 32'd1);
        if (prev_gnt == 4'b0) begin
          run_gnt = gnt;
          run_len = 0;
        end else begin
          chk("gnt_stable", 32'(gnt), 32'(run_gnt));
        end
        chk("count_seq", 32'(count), run_len);
        run_len++;
      end else if (prev_gnt != 4'b0) begin
        chk("count_cleared", 32'(count), 32'd0);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant: gnt %b ran %0d cycles with no expectation", run_gnt, run_len);
        end else begin
          e = exp_q.pop_front();
          chk("grant_id", 32'(run_gnt), 32'(e.gnt));
          chk("grant_cycles", run_len, e.cycles);
          chk("done_pulse", 32'(done), e.aborted ? 32'd0 : 32'(e.gnt));
        end
      end else begin
        chk("done_quiet", 32'(done), 32'd0);
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req = 4'b0;
    len = 32'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Single requester, len=3: 4 grant cycles, then DONE, then IDLE.
    len[7:0] = 8'd3;
    push(4'b0001, 4, 1'b0);
    req = 4'b0001;
    wait_done(20);
    req = 4'b0;
    chk("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);

    // All four requesting with len=0: rotation 0,1,2,3,0 from reset.
    do_reset();
    len = 32'b0;
    push(4'b0001, 1, 1'b0);
    push(4'b0010, 1, 1'b0);
    push(4'b0100, 1, 1'b0);
    push(4'b1000, 1, 1'b0);
    push(4'b0001, 1, 1'b0);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_done(10);
    req = 4'b0;

    // Maximum length: 256 grant cycles, count peaks at 255 without wrapping.
    len[7:0] = 8'd255;
    push(4'b0001, 256, 1'b0);
    req = 4'b0001;
    wait_done(300);
    req = 4'b0;

    // len changed mid-run is ignored: the grant still lasts 5 cycles.
    len[15:8] = 8'd4;
    push(4'b0010, 5, 1'b0);
    req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    len[15:8] = 8'd9;
    wait_done(20);
    req = 4'b0;

    // req2 dropped at count 2 of a len=6 run while req3 waits.
    len[23:16] = 8'd6;
    len[31:24] = 8'd1;
`ifdef SHARED_TIMER_ABORT_EN
    push(4'b0100, 3, 1'b1);
`else
    push(4'b0100, 7, 1'b0);
`endif
    push(4'b1000, 2, 1'b0);
    req = 4'b1100;
    wait_count(4'b0100, 8'd2, 10);
    req = 4'b1000;
`ifndef SHARED_TIMER_ABORT_EN
    wait_done(20);
`endif
    wait_done(20);
    req = 4'b0;

    // Reset at count 5 of a len=10 run aborts it; arbitration restarts at 0.
    len[23:16] = 8'd10;
    push(4'b0100, 6, 1'b1);
    req = 4'b0100;
    wait_count(4'b0100, 8'd5, 20);
    rst = 1'b0;
    req = 4'b0;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    rst = 1'b1;
    len[15:8]  = 8'd2;
    len[31:24] = 8'd0;
    push(4'b0010, 3, 1'b0);
    req = 4'b1010;
    wait_done(20);
    req = 4'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
